// File: rtl/out_pcm_seq.sv
// Sequential linear-to-G.711 compressor (A-law / u-law) with valid/ready on both sides.
// Optional build macro OUT_PCM_SAT_FLAG_EN adds a 'sat' output flagging clamped samples.
module out_pcm_seq #(
    parameter int SR_W     = 16,
    parameter int ULAW_MAX = 8158,
    parameter int ALAW_MAX = 4095
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SR_W-1:0] sr,
    input  logic            law,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      sp
`ifdef OUT_PCM_SAT_FLAG_EN
    ,
    output logic            sat
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_NORM,
        S_OUT
    } state_t;

    localparam logic [SR_W:0] U_LIM = (SR_W+1)'(ULAW_MAX);
    localparam logic [SR_W:0] A_LIM = (SR_W+1)'(ALAW_MAX);

    state_t          state_q, state_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic            law_q, law_d;
    logic [12:0]     r_q, r_d;
    logic [2:0]      count_q, count_d;
    logic [7:0]      sp_q, sp_d;
    logic            out_valid_q, out_valid_d;
`ifdef OUT_PCM_SAT_FLAG_EN
    logic            sat_pend_q, sat_pend_d;
    logic            sat_q, sat_d;
`endif

    // Magnitudes are one bit wider than the input so -2^(SR_W-1) negates cleanly.
    logic [SR_W:0] sr_ext;
    logic [SR_W:0] mag_u;
    logic [SR_W:0] mag_a;
    logic          u_over;
    logic          a_over;
    logic [12:0]   u_clamp;
    logic [11:0]   a_clamp;
    logic [12:0]   r_prep;

    assign sr_ext  = {sr_q[SR_W-1], sr_q};
    assign mag_u   = sr_q[SR_W-1] ? -sr_ext : sr_ext;
    assign mag_a   = sr_q[SR_W-1] ? ~sr_ext : sr_ext;
    assign u_over  = (mag_u > U_LIM);
    assign a_over  = (mag_a > A_LIM);
    assign u_clamp = u_over ? U_LIM[12:0] : mag_u[12:0];
    assign a_clamp = a_over ? A_LIM[11:0] : mag_a[11:0];
    assign r_prep  = law_q ? {a_clamp, 1'b0} : (u_clamp + 13'd33);

    logic       pos;
    logic [2:0] cap;
    logic       stop;
    logic [2:0] seg;
    logic [7:0] xor_mask;
    logic [7:0] code;

    assign pos      = ~sr_q[SR_W-1];
    assign cap      = law_q ? 3'd6 : 3'd7;
    assign stop     = r_q[12] | (count_q == cap);
    // A-law segment 0 never normalises, so its count saturates at cap with r[12] still clear.
    assign seg      = (law_q && !r_q[12]) ? 3'd0 : (3'd7 - count_q);
    assign xor_mask = law_q ? (pos ? 8'hD5 : 8'h55) : (pos ? 8'hFF : 8'h7F);
    assign code     = {1'b0, seg, r_q[11:8]} ^ xor_mask;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        law_d       = law_q;
        r_d         = r_q;
        count_d     = count_q;
        sp_d        = sp_q;
        out_valid_d = out_valid_q;
`ifdef OUT_PCM_SAT_FLAG_EN
        sat_pend_d  = sat_pend_q;
        sat_d       = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sr_d    = sr;
                    law_d   = law;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                r_d     = r_prep;
                count_d = '0;
`ifdef OUT_PCM_SAT_FLAG_EN
                sat_pend_d = law_q ? a_over : u_over;
`endif
                state_d = S_NORM;
            end
            S_NORM: begin
                if (stop) begin
                    sp_d        = code;
                    out_valid_d = 1'b1;
`ifdef OUT_PCM_SAT_FLAG_EN
                    sat_d       = sat_pend_q;
`endif
                    state_d     = S_OUT;
                end else begin
                    r_d     = {r_q[11:0], 1'b0};
                    count_d = count_q + 3'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
`ifdef OUT_PCM_SAT_FLAG_EN
                    sat_d       = 1'b0;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            law_q       <= 1'b0;
            r_q         <= '0;
            count_q     <= '0;
            sp_q        <= '0;
            out_valid_q <= 1'b0;
`ifdef OUT_PCM_SAT_FLAG_EN
            sat_pend_q  <= 1'b0;
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            law_q       <= law_d;
            r_q         <= r_d;
            count_q     <= count_d;
            sp_q        <= sp_d;
            out_valid_q <= out_valid_d;
`ifdef OUT_PCM_SAT_FLAG_EN
            sat_pend_q  <= sat_pend_d;
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign sp        = sp_q;
`ifdef OUT_PCM_SAT_FLAG_EN
    assign sat       = sat_q;
`endif

endmodule

// File: tb/tb_out_pcm_seq.sv
// Self-checking bench for out_pcm_seq: directed vector table, reset/backpressure sequences, random stream.
module tb_out_pcm_seq;

    localparam int NRAND = 3000;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sr;
    logic        law;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  sp;
`ifdef OUT_PCM_SAT_FLAG_EN
    logic        sat;
`endif

    int errors = 0;
    int checks = 0;

    out_pcm_seq #(.SR_W(16), .ULAW_MAX(8158), .ALAW_MAX(4095)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sr        (sr),
        .law       (law),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sp        (sp)
`ifdef OUT_PCM_SAT_FLAG_EN
        ,
        .sat       (sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lw;
        logic [15:0] s;
        logic [7:0]  sp;
        int          lat;
        logic        st;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference G.711 compressor built from segment thresholds.
    function automatic logic [7:0] ref_code(input logic lw, input logic [15:0] s);
        int v, mag, x, hb, seg, mant;
        bit p;
        v = int'($signed(s));
        p = (v >= 0);
        hb = 0;
        if (!lw) begin
            mag = p ? v : -v;
            if (mag > 8158) mag = 8158;
            x = mag + 33;
            for (int b = 0; b < 13; b++) if (x[b]) hb = b;
            seg  = hb - 5;
            mant = (x >> (seg + 1)) & 15;
            return 8'((seg << 4) | mant) ^ (p ? 8'hFF : 8'h7F);
        end else begin
            mag = p ? v : -v - 1;
            if (mag > 4095) mag = 4095;
            if (mag < 32) begin
                seg  = 0;
                mant = mag >> 1;
            end else begin
                for (int b = 0; b < 12; b++) if (mag[b]) hb = b;
                seg  = hb - 4;
                mant = (mag >> seg) & 15;
            end
            return 8'((seg << 4) | mant) ^ (p ? 8'hD5 : 8'h55);
        end
    endfunction

    // Called just after a rising edge with the block idle; returns code and edges-to-out_valid.
    task automatic xfer(input logic lw, input logic [15:0] s, output logic [7:0] code, output int lat);
        chk("xfer_in_ready", int'(in_ready), 1);
        law = lw;
        sr = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("xfer_timeout", 0, 1);
        code = sp;
    endtask

    logic [7:0]  got;
    int          lat;
    logic [7:0]  exp_q[$];
    int          rcv;
    bit          rand_active;

    initial begin
        vt[0]  = '{1'b0, 16'h0000, 8'hFF, 9, 1'b0};
        vt[1]  = '{1'b0, 16'hFFFF, 8'h7E, 9, 1'b0};
        vt[2]  = '{1'b0, 16'h1FDE, 8'h80, 2, 1'b0};
        vt[3]  = '{1'b0, 16'hE022, 8'h00, 2, 1'b0};
        vt[4]  = '{1'b1, 16'h0000, 8'hD5, 8, 1'b0};
        vt[5]  = '{1'b1, 16'hFFFF, 8'h55, 8, 1'b0};
        vt[6]  = '{1'b1, 16'h0FFF, 8'hAA, 2, 1'b0};
        vt[7]  = '{1'b1, 16'hF000, 8'h2A, 2, 1'b0};
        vt[8]  = '{1'b0, 16'h7FFF, 8'h80, 2, 1'b1};
        vt[9]  = '{1'b0, 16'h8000, 8'h00, 2, 1'b1};
        vt[10] = '{1'b1, 16'h7530, 8'hAA, 2, 1'b1};
        vt[11] = '{1'b0, 16'h0064, 8'hDF, 7, 1'b0};
        vt[12] = '{1'b1, 16'h0064, 8'hFC, 7, 1'b0};
        vt[13] = '{1'b1, 16'hFFE0, 8'h5A, 8, 1'b0};
        vt[14] = '{1'b0, 16'hF830, 8'h20, 4, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sr = '0;
        law = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sp", int'(sp), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rel_in_ready", int'(in_ready), 1);

        foreach (vt[i]) begin
            xfer(vt[i].lw, vt[i].s, got, lat);
            chk($sformatf("vec%0d_sp", i), int'(got), int'(vt[i].sp));
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
`ifdef OUT_PCM_SAT_FLAG_EN
            chk($sformatf("vec%0d_sat", i), int'(sat), int'(vt[i].st));
`endif
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_hs_valid", i), int'(out_valid), 0);
`ifdef OUT_PCM_SAT_FLAG_EN
            chk($sformatf("vec%0d_hs_sat", i), int'(sat), 0);
`endif
        end

        // Reset mid-NORM: leaves a non-zero sp from the previous transfer so the clear is visible.
        xfer(1'b0, 16'h0000, got, lat);
        chk("pre_rst_sp", int'(got), 8'hFF);
        @(posedge clk);
        #1;
        law = 1'b0;
        sr = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_sp", int'(sp), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        begin
            int seen = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("midrst_no_output", seen, 0);
        end
        xfer(1'b1, 16'h0064, got, lat);
        chk("postrst_sp", int'(got), 8'hFC);
        chk("postrst_lat", lat, 7);
        @(posedge clk);
        #1;

        // Backpressure with a competing sample held on the input.
        out_ready = 1'b0;
        xfer(1'b1, 16'h0FFF, got, lat);
        chk("bp_sp", int'(got), 8'hAA);
        law = 1'b0;
        sr = 16'h0064;
        in_valid = 1'b1;
        begin
            int bad_sp = 0;
            int bad_rdy = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (!out_valid || sp != 8'hAA) bad_sp++;
                if (in_ready) bad_rdy++;
            end
            chk("bp_sp_stable", bad_sp, 0);
            chk("bp_in_ready_low", bad_rdy, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_valid", int'(out_valid), 0);
        chk("bp_hs_in_ready", int'(in_ready), 1);
        begin
            int seen = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("bp_no_second_accept", seen, 0);
        end

        // Random stream against the reference model.
        out_ready = 1'b0;
        rcv = 0;
        rand_active = 1'b1;
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    logic [31:0] v;
                    logic signed [15:0] t;
                    int w;
                    bit acc;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    v = $urandom;
                    t = v[15:0];
                    law = v[16];
                    sr = t >>> v[20:17];
                    in_valid = 1'b1;
                    acc = 1'b0;
                    w = 0;
                    while (!acc && w < 100) begin
                        @(negedge clk);
                        if (in_ready) acc = 1'b1;
                        else w++;
                    end
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    if (!acc) begin
                        chk("rand_accept_timeout", 0, 1);
                        break;
                    end
                end
                begin
                    int d = 0;
                    while (exp_q.size() != 0 && d < 400) begin
                        @(posedge clk);
                        d++;
                    end
                end
                chk("rand_drain", exp_q.size(), 0);
                chk("rand_count", rcv, NRAND);
                rand_active = 1'b0;
            end
            begin
                while (rand_active) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                while (rand_active) begin
                    @(negedge clk);
                    if (in_valid && in_ready) exp_q.push_back(ref_code(law, sr));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) chk("rand_dup", 1, 0);
                        else begin
                            chk("rand_sp", int'(sp), int'(exp_q.pop_front()));
                            rcv++;
                        end
                    end
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
